// File: rtl/plab5_mcore_net_to_mem_resp_queue_pkg.sv
// Shared widths and message-layout helpers for the core-side memory response receive stage.
// Field layouts: net msg = {dest, src, net_opaque, payload}; mem resp = {type, opaque, len, data}.
package plab5_mcore_net_to_mem_resp_queue_pkg;

    localparam int MEM_TYPE_NBITS = 3;
    localparam int ERR_CNT_NBITS  = 8;
    localparam logic [ERR_CNT_NBITS-1:0] ERR_CNT_MAX = '1;

    function automatic int mem_len_nbits(input int md);
        return $clog2(md / 8);
    endfunction

    function automatic int mem_resp_nbits(input int mo, input int md);
        return MEM_TYPE_NBITS + mo + mem_len_nbits(md) + md;
    endfunction

    function automatic int net_nbits(input int np, input int no, input int ns);
        return np + no + 2 * ns;
    endfunction

endpackage

// File: rtl/plab5_mcore_net_to_mem_resp_queue_if.sv
// Network-side and core-side val/rdy bundle of the memory response receive stage.
// A transfer happens on a rising edge where val and rdy are both 1; val never waits on rdy.
interface plab5_mcore_net_to_mem_resp_queue_if
    import plab5_mcore_net_to_mem_resp_queue_pkg::*;
#(
    parameter int NP    = mem_resp_nbits(8, 32),
    parameter int NS    = 3,
    parameter int NET_W = net_nbits(NP, 4, NS)
);
    logic [NET_W-1:0] in_msg;
    logic             in_val;
    logic             in_rdy;
    logic [NP-1:0]    out_msg;
    logic [NS-1:0]    out_src;
    logic             out_val;
    logic             out_rdy;

    modport slave (
        input  in_msg, in_val, out_rdy,
        output in_rdy, out_msg, out_src, out_val
    );

    modport master (
        output in_msg, in_val, out_rdy,
        input  in_rdy, out_msg, out_src, out_val
    );
endinterface

// File: rtl/plab5_mcore_resp_queue2.sv
// Generic 2-entry normal (no bypass) val/rdy queue; enq_rdy depends only on the stored count.
module plab5_mcore_resp_queue2 #(
    parameter int p_msg_nbits = 48
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_enq_val,
    input  logic [p_msg_nbits-1:0] i_enq_msg,
    output logic                   o_enq_rdy,
    output logic                   o_deq_val,
    output logic [p_msg_nbits-1:0] o_deq_msg,
    input  logic                   i_deq_rdy
);
    logic [p_msg_nbits-1:0] r_data [2];
    logic                   r_enq_ptr;
    logic                   r_deq_ptr;
    logic [1:0]             r_count;
    logic                   w_enq;
    logic                   w_deq;

    // A full queue refuses input even when it drains this cycle, so no rdy path from deq side.
    assign o_enq_rdy = (r_count != 2'd2);
    assign o_deq_val = (r_count != 2'd0);
    assign o_deq_msg = r_data[r_deq_ptr];
    assign w_enq     = i_enq_val & o_enq_rdy;
    assign w_deq     = o_deq_val & i_deq_rdy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_enq_ptr <= 1'b0;
            r_deq_ptr <= 1'b0;
            r_count   <= 2'd0;
        end else begin
            if (w_enq) r_enq_ptr <= ~r_enq_ptr;
            if (w_deq) r_deq_ptr <= ~r_deq_ptr;
            case ({w_enq, w_deq})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_enq) r_data[r_enq_ptr] <= i_enq_msg;
    end
endmodule

// File: rtl/plab5_mcore_net_to_mem_resp_queue.sv
// Core-side receive stage: strips the network header, restores the core-local opaque bits and
// queues memory responses for the core. Optional dest check: PLAB5_MCORE_NET_DEST_CHECK_EN.
module plab5_mcore_net_to_mem_resp_queue
    import plab5_mcore_net_to_mem_resp_queue_pkg::*;
#(
    parameter int p_net_dest          = 0,
    parameter int p_mem_opaque_nbits  = 8,
    parameter int p_mem_data_nbits    = 32,
    parameter int p_net_opaque_nbits  = 4,
    parameter int p_net_srcdest_nbits = 3
) (
    input  logic                     clk,
    input  logic                     reset_n,
    plab5_mcore_net_to_mem_resp_queue_if.slave io,
    output logic                     err_flag,
    output logic [ERR_CNT_NBITS-1:0] err_count
);
    localparam int MO            = p_mem_opaque_nbits;
    localparam int MD            = p_mem_data_nbits;
    localparam int NO            = p_net_opaque_nbits;
    localparam int NS            = p_net_srcdest_nbits;
    localparam int LEN_NB        = mem_len_nbits(MD);
    localparam int NP            = mem_resp_nbits(MO, MD);
    localparam int OPQ_CLR_NBITS = NS;
    localparam logic [NS-1:0] DEST_ID = p_net_dest[NS-1:0];

    logic [NS-1:0]             w_dest;
    logic [NS-1:0]             w_src;
    logic [NP-1:0]             w_payload;
    logic [MEM_TYPE_NBITS-1:0] w_type;
    logic [MO-1:0]             w_opaque;
    logic [MO-1:0]             w_opaque_clr;
    logic [LEN_NB-1:0]         w_len;
    logic [MD-1:0]             w_data;
    logic [NP-1:0]             w_resp;
    logic [NP+NS-1:0]          w_deq_msg;
    logic                      w_accept;
    logic                      w_unused_bits;

    assign w_payload = io.in_msg[NP-1:0];
    assign w_src     = io.in_msg[NP+NO +: NS];
    assign w_dest    = io.in_msg[NP+NO+NS +: NS];

    assign w_data    = w_payload[MD-1:0];
    assign w_len     = w_payload[MD +: LEN_NB];
    assign w_opaque  = w_payload[MD+LEN_NB +: MO];
    assign w_type    = w_payload[MD+LEN_NB+MO +: MEM_TYPE_NBITS];

    // The request side stashed the bank id in the top opaque bits; the core never set them.
    assign w_opaque_clr = {{OPQ_CLR_NBITS{1'b0}}, w_opaque[MO-OPQ_CLR_NBITS-1:0]};
    assign w_resp       = {w_type, w_opaque_clr, w_len, w_data};

    plab5_mcore_resp_queue2 #(
        .p_msg_nbits (NP + NS)
    ) u_queue (
        .clk       (clk),
        .rst_n     (reset_n),
        .i_enq_val (io.in_val & w_accept),
        .i_enq_msg ({w_resp, w_src}),
        .o_enq_rdy (io.in_rdy),
        .o_deq_val (io.out_val),
        .o_deq_msg (w_deq_msg),
        .i_deq_rdy (io.out_rdy)
    );

    assign io.out_msg = w_deq_msg[NP+NS-1:NS];
    assign io.out_src = w_deq_msg[NS-1:0];

`ifdef PLAB5_MCORE_NET_DEST_CHECK_EN
    logic                     w_dest_ok;
    logic                     w_fire;
    logic                     r_err_flag;
    logic [ERR_CNT_NBITS-1:0] r_err_count;

    // Misrouted messages still complete the handshake so they cannot wedge the network.
    assign w_dest_ok = (w_dest == DEST_ID);
    assign w_accept  = w_dest_ok;
    assign w_fire    = io.in_val & io.in_rdy;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_err_flag  <= 1'b0;
            r_err_count <= '0;
        end else if (w_fire && !w_dest_ok) begin
            r_err_flag <= 1'b1;
            if (r_err_count != ERR_CNT_MAX) r_err_count <= r_err_count + 8'd1;
        end
    end

    assign err_flag      = r_err_flag;
    assign err_count     = r_err_count;
    assign w_unused_bits = ^io.in_msg[NP +: NO];
`else
    assign w_accept      = 1'b1;
    assign err_flag      = 1'b0;
    assign err_count     = '0;
    assign w_unused_bits = ^{io.in_msg[NP +: NO], w_dest ^ DEST_ID};
`endif
endmodule
